// File: rtl/mips_mc_dp.sv
// mips_mc_dp: multicycle MIPS subset core sharing one memory port for fetch and data.
// Define MIPS_MC_RETIRE_CNT_EN to add the retire_cnt output and its counter.
module mips_mc_dp #(
    parameter int          NREG     = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [31:0]     pc,
    output logic [31:0]     instr,
    output logic [2:0]      state,
    output logic            halted
`ifdef MIPS_MC_RETIRE_CNT_EN
    ,
    output logic [31:0]     retire_cnt
`endif
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } st_t;
    localparam int AW = $clog2(NREG);
    st_t             st;
    logic [XLEN-1:0] gpr [NREG];
    logic [XLEN-1:0] a, b, res, rsv, rtv, sx, alu, ea;
    logic [5:0]      op, fn;
    logic [4:0]      rs, rt, rd, dst;
    logic [15:0]     imm;
    logic [31:0]     npc;
    logic            is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, legal, wen;
    assign op      = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign fn      = instr[5:0];
    assign imm     = instr[15:0];
    assign is_addu = op == 6'h00 && fn == 6'h21;
    assign is_subu = op == 6'h00 && fn == 6'h23;
    assign is_ori  = op == 6'h0D;
    assign is_lui  = op == 6'h0F;
    assign is_lw   = op == 6'h23;
    assign is_sw   = op == 6'h2B;
    assign is_beq  = op == 6'h04;
    assign is_j    = op == 6'h02;
    assign legal   = is_addu || is_subu || is_ori || is_lui || is_lw || is_sw || is_beq || is_j;
    // out-of-range and zero register indices read as zero and never get written
    assign rsv     = (rs != 5'd0 && int'(rs) < NREG) ? gpr[rs[AW-1:0]] : '0;
    assign rtv     = (rt != 5'd0 && int'(rt) < NREG) ? gpr[rt[AW-1:0]] : '0;
    assign dst     = op == 6'h00 ? rd : rt;
    assign wen     = dst != 5'd0 && int'(dst) < NREG;
    assign sx      = XLEN'($signed(imm));
    assign ea      = a + sx;
    assign alu     = is_addu ? a + b : is_subu ? a - b : is_ori ? a | XLEN'(imm) : XLEN'($signed({imm, 16'h0}));
    assign npc     = (is_beq && a == b) ? pc + {{14{imm[15]}}, imm, 2'b00} :
                     is_j ? {pc[31:28], instr[25:0], 2'b00} : pc;
    assign state   = st;
    assign halted  = st == HALT;
    // requests are raised on the edge that enters FETCH/MEM so a zero-wait ack completes in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= FETCH;
            pc        <= PC_RESET;
            instr     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            a         <= '0;
            b         <= '0;
            res       <= '0;
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
        end else begin
            case (st)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        instr   <= mem_rdata[31:0];
                        pc      <= pc + 32'd4;
                        mem_req <= 1'b0;
                        st      <= DECODE;
                    end
                end
                DECODE: begin
                    a  <= rsv;
                    b  <= rtv;
                    st <= legal ? EXEC : HALT;
                end
                EXEC: begin
                    if (is_lw || is_sw) begin
                        if (ea[1:0] != 2'b00) st <= HALT;
                        else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_sw;
                            mem_addr  <= ea[31:0];
                            mem_wdata <= b;
                            st        <= MEM;
                        end
                    end else if (is_beq || is_j) begin
                        pc       <= npc;
                        mem_req  <= 1'b1;
                        mem_addr <= npc;
                        st       <= FETCH;
                    end else begin
                        res <= alu;
                        st  <= WB;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        res     <= mem_rdata;
                        mem_we  <= 1'b0;
                        mem_req <= !is_lw;
                        if (!is_lw) mem_addr <= pc;
                        st      <= is_lw ? WB : FETCH;
                    end
                end
                WB: begin
                    if (wen) gpr[dst[AW-1:0]] <= res;
                    mem_req  <= 1'b1;
                    mem_addr <= pc;
                    st       <= FETCH;
                end
                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    st      <= HALT;
                end
            endcase
        end
    end
`ifdef MIPS_MC_RETIRE_CNT_EN
    logic retire;
    assign retire = st == WB || (st == MEM && mem_ack && is_sw) || (st == EXEC && (is_beq || is_j));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retire_cnt <= '0;
        else if (retire) retire_cnt <= retire_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mips_mc_dp.sv
// tb_mips_mc_dp: directed + random program run against an instruction-level model of mips_mc_dp.
module tb_mips_mc_dp;
    localparam int NR = 8;
    localparam logic [31:0] LOOP = 32'h0000_30C4;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
        int          w;
        int          rc;
        bit          stable;
    } tx_t;

    logic        clk = 0, rst = 0, auto = 1;
    logic        mem_req, mem_we, mem_ack, halted, r_ack, m_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, r_rdata, m_rdata, pc, instr;
    logic [2:0]  state;
`ifdef MIPS_MC_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif
    logic [31:0] mem [logic [31:0]];
    logic [31:0] prog [logic [31:0]];
    logic [31:0] dm [logic [31:0]];
    logic [31:0] r [32];
    logic [31:0] mpc;
    tx_t         txq [$];
    int          waits [1024];
    int          nreq = 0, cyc = 0, nvec = 0, nerr = 0;
    int          ninst, prev_cyc, prev_lat, prev_dw;

    assign mem_ack   = auto ? r_ack : m_ack;
    assign mem_rdata = auto ? r_rdata : m_rdata;

    mips_mc_dp #(.NREG(NR), .PC_RESET(32'h0000_3000), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
        .instr(instr), .state(state), .halted(halted)
`ifdef MIPS_MC_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    // memory responder: ack after waits[] cycles, log each completed transfer
    initial begin
        tx_t t;
        int  cnt;
        cnt = 0;
        r_ack = 0;
        r_rdata = '0;
        t = '{default: 0};
        forever begin
            @(negedge clk);
            if (r_ack) begin
                if (t.we) mem[t.addr] = t.wdata;
                t.cyc = cyc;
                txq.push_back(t);
                cnt = 0;
            end
            r_ack = 0;
            if (rst || !mem_req || !auto) cnt = 0;
            else begin
                if (cnt == 0) begin
                    t.we = mem_we;
                    t.addr = mem_addr;
                    t.wdata = mem_wdata;
                    t.w = waits[nreq % 1024];
                    t.stable = 1;
                    t.rc = 0;
`ifdef MIPS_MC_RETIRE_CNT_EN
                    t.rc = int'(retire_cnt);
`endif
                    nreq++;
                end else if (mem_we !== t.we || mem_addr !== t.addr || mem_wdata !== t.wdata) t.stable = 0;
                if (cnt >= t.w) begin
                    r_ack = 1;
                    if (mem.exists(mem_addr)) r_rdata = mem[mem_addr];
                    else r_rdata = '0;
                end
                cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic pop(output tx_t t);
        for (int n = 0; n < 200 && txq.size() == 0; n++) @(negedge clk);
        chk("tx_timeout", txq.size() != 0, 1);
        if (txq.size() == 0) begin
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
            $finish;
        end else t = txq.pop_front();
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a] = w;
        prog[a] = w;
    endtask

    function automatic logic [31:0] ei(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] rv(input logic [4:0] i);
        return (i != 0 && int'(i) < NR) ? r[i] : 32'h0;
    endfunction

    task automatic wr(input logic [4:0] i, input logic [31:0] v);
        if (i != 0 && int'(i) < NR) r[i] = v;
    endtask

    // one instruction of the ISA model against the logged bus transfers
    task automatic step(output logic [31:0] sd, output int fc);
        tx_t f, d;
        logic [31:0] iw, a, b, sx, ea;
        int lat, dw;
        pop(f);
        chk("fetch_addr", f.addr, mpc);
        chk("fetch_we", f.we, 0);
        chk("fetch_stable", f.stable, 1);
        if (prev_lat > 0) chk("latency", f.cyc - prev_cyc, prev_lat + prev_dw + f.w);
`ifdef MIPS_MC_RETIRE_CNT_EN
        chk("retire_cnt", f.rc, ninst);
`endif
        iw = prog.exists(mpc) ? prog[mpc] : 32'h0;
        a = rv(iw[25:21]);
        b = rv(iw[20:16]);
        sx = {{16{iw[15]}}, iw[15:0]};
        ea = a + sx;
        mpc = mpc + 4;
        lat = 4;
        dw = 0;
        sd = '0;
        fc = f.cyc;
        case (iw[31:26])
            6'h00: if (iw[5:0] == 6'h21) wr(iw[15:11], a + b);
                   else if (iw[5:0] == 6'h23) wr(iw[15:11], a - b);
            6'h0D: wr(iw[20:16], a | {16'h0, iw[15:0]});
            6'h0F: wr(iw[20:16], {iw[15:0], 16'h0});
            6'h23: begin
                pop(d);
                chk("lw_addr", d.addr, ea);
                chk("lw_we", d.we, 0);
                chk("lw_stable", d.stable, 1);
                wr(iw[20:16], dm.exists(ea) ? dm[ea] : 32'h0);
                dw = d.w;
                lat = 5;
            end
            6'h2B: begin
                pop(d);
                chk("sw_addr", d.addr, ea);
                chk("sw_we", d.we, 1);
                chk("sw_data", d.wdata, b);
                chk("sw_stable", d.stable, 1);
                dm[ea] = b;
                dw = d.w;
                sd = d.wdata;
            end
            6'h04: begin
                if (a == b) mpc = mpc + (sx << 2);
                lat = 3;
            end
            6'h02: begin
                mpc = {mpc[31:28], iw[25:0], 2'b00};
                lat = 3;
            end
            default: ;
        endcase
        prev_cyc = f.cyc;
        prev_lat = lat;
        prev_dw = dw;
        ninst++;
    endtask

    initial begin
        logic [31:0] sd, s3, s4, s10, w;
        int fc, c0, k;
        logic [4:0] ra, rb, rc;
        m_ack = 0;
        m_rdata = '0;
        for (int i = 0; i < 1024; i++) waits[i] = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) waits[i] = 0;
        for (int i = 4; i < 7; i++) waits[i] = 3;
        #2 rst = 1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 32'h3000);
        chk("rst_ir", instr, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_halted", halted, 0);

        put(32'h3000, ei(6'h0D, 0, 1, 16'h1234));
        put(32'h3004, ei(6'h0D, 0, 2, 16'h0001));
        put(32'h3008, er(1, 2, 3, 6'h21));
        put(32'h300C, ei(6'h2B, 0, 3, 16'h0000));
        put(32'h3010, ei(6'h23, 0, 4, 16'h0000));
        put(32'h3014, ei(6'h2B, 0, 4, 16'h0004));
        put(32'h3018, ei(6'h0D, 0, 9, 16'h0005));
        put(32'h301C, er(9, 0, 10, 6'h21));
        put(32'h3020, ei(6'h2B, 0, 10, 16'h0008));
        for (k = 0; k < 40; k++) begin
            ra = 5'($urandom_range(0, 11));
            rb = 5'($urandom_range(0, 11));
            rc = 5'($urandom_range(0, 11));
            w = $urandom;
            case ($urandom_range(0, 6))
                0: w = ei(6'h0D, ra, rb, w[15:0]);
                1: w = ei(6'h0F, 0, rb, w[15:0]);
                2: w = er(ra, rb, rc, 6'h21);
                3: w = er(ra, rb, rc, 6'h23);
                4: w = ei(6'h2B, 0, rb, {10'h0, w[3:0], 2'b00});
                5: w = ei(6'h23, 0, rb, {10'h0, w[3:0], 2'b00});
                default: w = (k < 38) ? ei(6'h04, ra, rb, {15'h0, w[0]}) : ei(6'h0D, ra, rb, w[15:0]);
            endcase
            put(32'h3024 + 32'(4 * k), w);
        end
        put(LOOP, ei(6'h04, 1, 1, 16'hFFFF));
        for (int i = 0; i < 32; i++) r[i] = '0;
        mpc = 32'h3000;
        ninst = 0;
        prev_lat = 0;
        prev_cyc = 0;
        prev_dw = 0;
        nreq = 0;
        @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;
        c0 = cyc;
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 32'h3000);

        for (int i = 0; i < 3; i++) step(sd, fc);
        step(s3, fc);
        chk("three_instr_cycles", fc - c0, 13);
        step(sd, fc);
        step(s4, fc);
        step(sd, fc);
        step(sd, fc);
        step(s10, fc);
        chk("gpr3_stored", s3, 32'h1235);
        chk("gpr4_stored", s4, 32'h1235);
        chk("gpr10_nreg8", s10, 0);
        chk("nreg8_no_halt", halted, 0);
        for (int n = 0; n < 120 && mpc != LOOP; n++) step(sd, fc);
        for (int n = 0; n < 4; n++) step(sd, fc);

        @(posedge clk);
        #1 rst = 1;
        #1;
        chk("halt_rst_pc", pc, 32'h3000);
        chk("halt_rst_req", mem_req, 0);
        @(posedge clk);
        #1;
        mem.delete();
        put(32'h3000, 32'hFC00_0000);
        txq.delete();
        rst = 0;
        for (int n = 0; n < 20 && !halted; n++) begin
            @(posedge clk);
            #1;
        end
        chk("ill_halted", halted, 1);
        chk("ill_state", state, 7);
        chk("ill_req", mem_req, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("ill_sticky", halted, 1);
        chk("ill_sticky_req", mem_req, 0);

        rst = 1;
        @(posedge clk);
        #1;
        put(32'h3000, ei(6'h23, 0, 5, 16'h0002));
        txq.delete();
        rst = 0;
        @(posedge clk);
        #1;
        chk("restart_req", mem_req, 1);
        chk("restart_addr", mem_addr, 32'h3000);
        for (int n = 0; n < 20 && !halted; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("mis_halted", halted, 1);
        chk("mis_req", mem_req, 0);
        chk("mis_no_data_req", txq.size(), 1);

        rst = 1;
        auto = 0;
        @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;
        m_rdata = ei(6'h0D, 0, 1, 16'h00AA);
        m_ack = 1;
        @(posedge clk);
        #1;
        m_ack = 0;
        chk("man_ir", instr, ei(6'h0D, 0, 1, 16'h00AA));
        for (int n = 0; n < 10 && !(state == 0 && mem_req); n++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("man_wait_req", mem_req, 1);
        chk("man_wait_addr", mem_addr, 32'h3004);
        rst = 1;
        #1;
        chk("mid_rst_ir", instr, 0);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_pc", pc, 32'h3000);
        @(posedge clk);
        #1;
        rst = 0;
        m_ack = 1;
        m_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("late_ack_ir", instr, 0);
        chk("late_ack_state", state, 0);
        chk("late_ack_req", mem_req, 1);
        chk("late_ack_addr", mem_addr, 32'h3000);
        m_rdata = ei(6'h0F, 0, 2, 16'h8000);
        @(posedge clk);
        #1;
        m_ack = 0;
        chk("refetch_ir", instr, ei(6'h0F, 0, 2, 16'h8000));
        chk("refetch_pc", pc, 32'h3004);
        chk("refetch_state", state, 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mips_mc_dp.md
MIPS_MC_DP -- requirements
Module: mips_mc_dp

Interface
REQ-001 SHALL provide parameter NREG, default 32, number of GPRs; legal values are 8, 16 or 32.
REQ-002 SHALL provide parameter PC_RESET, default 32'h0000_3000, PC value loaded on reset.
REQ-003 SHALL provide parameter XLEN, default 32, width of GPRs, ALU and data bus; legal values are 32 or 64, and instructions are always 32 bits.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port mem_req, output, 1 bit, memory request valid.
REQ-007 SHALL have port mem_we, output, 1 bit, memory write enable (1 = store).
REQ-008 SHALL have port mem_addr, output, 32 bits, byte address, word-aligned.
REQ-009 SHALL have port mem_wdata, output, XLEN bits, store data.
REQ-010 SHALL have port mem_rdata, input, XLEN bits, load or fetch data; instruction = mem_rdata[31:0].
REQ-011 SHALL have port mem_ack, input, 1 bit, transfer complete in the current cycle.
REQ-012 SHALL have port pc, output, 32 bits, current PC.
REQ-013 SHALL have port instr, output, 32 bits, the latched instruction register (IR).
REQ-014 SHALL have port state, output, 3 bits, FSM encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-015 SHALL have port halted, output, 1 bit, high while in HALT.

Function
REQ-016 SHALL execute addu, subu, ori, lui, lw, sw, beq and j; any other opcode/funct combination SHALL enter HALT.
REQ-017 In FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack, IR<=mem_rdata[31:0], pc<=pc+4, next state DECODE.
REQ-018 In DECODE: latch A<=GPR[rs] and B<=GPR[rt]; next state EXEC, or HALT if the instruction is illegal.
REQ-019 In EXEC:
- addu/subu/ori/lui: ALU result latched, next state WB.
- lw/sw: address = A + sign-extended imm16, next state MEM.
- beq: if A==B then pc<=pc+(sext(imm16)<<2); next state FETCH.
- j: pc<={pc[31:28],imm26,2'b00}; next state FETCH.
REQ-020 ori SHALL zero-extend imm16, and lui SHALL produce {imm16,16'h0} sign-extended to XLEN.
REQ-021 addu/subu SHALL wrap modulo 2^XLEN without any overflow indication.
REQ-022 In MEM: mem_req=1, mem_we=(sw), mem_wdata=B; on mem_ack, lw latches mem_rdata and goes to WB, sw goes to FETCH.
REQ-023 In WB: write the result to rd (R-type) or rt (ori/lui/lw); next state FETCH.
REQ-024 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0; wait cycles are unbounded.
REQ-025 mem_ack sampled while mem_req=0 SHALL be ignored.
REQ-026 mem_ack in the first cycle of a request SHALL complete that request with zero wait.
REQ-027 Zero-wait latency SHALL be: R/ori/lui 4 cycles, lw 5, sw 4, beq/j 3.
REQ-028 GPR[0] SHALL read as 0, and writes to it SHALL be discarded.
REQ-029 Register indices >= NREG SHALL read as 0, and writes to them SHALL be discarded.
REQ-030 A misaligned lw/sw address (addr[1:0]!=0) SHALL enter HALT with no memory request issued.
REQ-031 HALT SHALL be exited only by rst; mem_req SHALL be 0 in HALT.

Reset
REQ-032 rst=1 SHALL immediately force: state=FETCH, pc=PC_RESET, IR=0, all GPRs=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
REQ-033 rst asserted mid-transfer SHALL abandon the transfer; any mem_ack arriving after rst SHALL be ignored.
REQ-034 On the first clock edge after rst falls, the block SHALL assert mem_req with mem_addr=PC_RESET.

Configuration
REQ-035 Macro MIPS_MC_RETIRE_CNT_EN defined: the block SHALL add output retire_cnt, 32 bits, reset 0, incremented by 1 on every instruction completion (WB exit, sw MEM exit, beq/j EXEC exit); it wraps at 2^32 and does not count in HALT.
REQ-036 Macro MIPS_MC_RETIRE_CNT_EN undefined: the block SHALL have no retire_cnt port and no counter logic, with all other behaviour identical.

Verification
REQ-037 Zero-wait memory, program ori $1,$0,0x1234; ori $2,$0,0x0001; addu $3,$1,$2 -> GPR3=0x1235 after 12 cycles, pc=0x300C.
REQ-038 sw $3,0($0), then lw $4,0($0), with mem_ack delayed 3 cycles on each request -> mem_addr/mem_wdata stable while waiting, GPR4=0x1235.
REQ-039 beq $1,$1,-1 -> pc returns to the beq address every 3 cycles; retire_cnt increments by 1 per loop when the macro is enabled.
REQ-040 NREG=8, ori $9,$0,5 then addu $10,$9,$0 -> GPR10 reads 0, and no HALT occurs.
REQ-041 Opcode 6'h3F, or lw at address 0x2 -> halted=1, mem_req=0; asserting rst then restarts the fetch at 0x3000.
REQ-042 rst pulse during a FETCH wait, with mem_ack arriving 1 cycle later -> ack ignored, IR=0, new fetch from PC_RESET.
